// File: rtl/inst_loader_pkg.sv
// Shared types and default sizing for the instruction-memory loader.
package inst_loader_pkg;

    localparam int unsigned DEF_A = 10;
    localparam int unsigned DEF_W = 9;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        DONE,
        FAIL
    } state_e;

endpackage

// File: rtl/inst_ram.sv
// Writable instruction RAM: one synchronous write port, one combinational read port.
module inst_ram
    import inst_loader_pkg::*;
#(
    parameter int unsigned A = DEF_A,
    parameter int unsigned W = DEF_W
) (
    input  logic         Clk,
    input  logic         WrEn,
    input  logic [A-1:0] WrAddr,
    input  logic [W-1:0] WrData,
    input  logic [A-1:0] RdAddr,
    output logic [W-1:0] RdData
);

    logic [W-1:0] mem_q [1 << A];

    always_ff @(posedge Clk) begin
        if (WrEn) begin
            mem_q[WrAddr] <= WrData;
        end
    end

    assign RdData = mem_q[RdAddr];

endmodule

// File: rtl/inst_loader.sv
// Streams machine-code words into the instruction RAM from address 0, checks an XOR
// checksum, and keeps the core in reset until a load completes cleanly.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int unsigned A = DEF_A,
    parameter int unsigned W = DEF_W
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic [A:0]   LoadLen,
    input  logic [W-1:0] ExpSum,
    input  logic         InValid,
    input  logic [W-1:0] InData,
    output logic         InReady,
    output logic         WrEn,
    output logic [A-1:0] WrAddr,
    output logic [W-1:0] WrData,
    output logic         Busy,
    output logic         Done,
    output logic         Error,
    output logic         CoreHold
);

    localparam logic [A:0] MAX_LEN = {1'b1, {A{1'b0}}};
    localparam logic [A:0] ONE     = {{A{1'b0}}, 1'b1};

    state_e       state_q, state_d;
    logic [A:0]   count_q, count_d;
    logic [A:0]   len_q, len_d;
    logic [W-1:0] sum_q, sum_d;
    logic [W-1:0] exp_q, exp_d;
    logic         in_ready_q, in_ready_d;
    logic         wr_en_q, wr_en_d;
    logic [A-1:0] wr_addr_q, wr_addr_d;
    logic [W-1:0] wr_data_q, wr_data_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         error_q, error_d;
    logic         core_hold_q, core_hold_d;
    logic         beat_c;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            len_q       <= '0;
            sum_q       <= '0;
            exp_q       <= '0;
            in_ready_q  <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            core_hold_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            len_q       <= len_d;
            sum_q       <= sum_d;
            exp_q       <= exp_d;
            in_ready_q  <= in_ready_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            core_hold_q <= core_hold_d;
        end
    end

    // A beat is qualified by the registered ready, which is high exactly in LOAD.
    assign beat_c = InValid && in_ready_q;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        len_d     = len_q;
        sum_d     = sum_q;
        exp_d     = exp_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = done_q;
        error_d   = error_q;

        unique case (state_q)
            IDLE, DONE, FAIL: begin
                if (Start) begin
                    if (LoadLen == '0 || LoadLen > MAX_LEN) begin
                        state_d = FAIL;
                        done_d  = 1'b0;
                        error_d = 1'b1;
                    end else begin
                        state_d = LOAD;
                        len_d   = LoadLen;
                        exp_d   = ExpSum;
                        count_d = '0;
                        sum_d   = '0;
                        done_d  = 1'b0;
                        error_d = 1'b0;
                    end
                end
            end
            LOAD: begin
                if (beat_c) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = count_q[A-1:0];
                    wr_data_d = InData;
                    count_d   = count_q + ONE;
                    sum_d     = sum_q ^ InData;
                    if (count_q == len_q - ONE) begin
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                // sum_q already folds in the final word accepted on the previous edge.
                if (sum_q == exp_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = FAIL;
                    error_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == LOAD);
        busy_d      = (state_d == LOAD) || (state_d == CHECK);
        core_hold_d = (state_d != DONE);
    end

    assign InReady  = in_ready_q;
    assign WrEn     = wr_en_q;
    assign WrAddr   = wr_addr_q;
    assign WrData   = wr_data_q;
    assign Busy     = busy_q;
    assign Done     = done_q;
    assign Error    = error_q;
    assign CoreHold = core_hold_q;

endmodule

// File: tb/tb_inst_loader.sv
// Scoreboard bench for inst_loader paired with inst_ram.
module tb_inst_loader;

    localparam int unsigned A = 10;
    localparam int unsigned W = 9;

    logic         Clk;
    logic         Reset;
    logic         Start;
    logic [A:0]   LoadLen;
    logic [W-1:0] ExpSum;
    logic         InValid;
    logic [W-1:0] InData;
    logic         InReady;
    logic         WrEn;
    logic [A-1:0] WrAddr;
    logic [W-1:0] WrData;
    logic         Busy;
    logic         Done;
    logic         Error;
    logic         CoreHold;
    logic [A-1:0] RdAddr;
    logic [W-1:0] RdData;

    int checks   = 0;
    int failures = 0;

    logic [A+W-1:0] sb[$];
    logic [A-1:0]   exp_addr;

    inst_loader #(.A(A), .W(W)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .LoadLen(LoadLen), .ExpSum(ExpSum),
        .InValid(InValid), .InData(InData), .InReady(InReady), .WrEn(WrEn),
        .WrAddr(WrAddr), .WrData(WrData), .Busy(Busy), .Done(Done), .Error(Error),
        .CoreHold(CoreHold)
    );

    inst_ram #(.A(A), .W(W)) ram (
        .Clk(Clk), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
        .RdAddr(RdAddr), .RdData(RdData)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write the loader presents must match the next expected write.
    always @(negedge Clk) begin
        if (WrEn === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_write_addr", 32'(WrAddr), 32'hFFFF_FFFF);
            end else begin
                logic [A+W-1:0] e;
                e = sb.pop_front();
                check("wr_addr", 32'(WrAddr), 32'(e[A+W-1:W]));
                check("wr_data", 32'(WrData), 32'(e[W-1:0]));
            end
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_start(input logic [A:0] len, input logic [W-1:0] es);
        Start   = 1'b1;
        LoadLen = len;
        ExpSum  = es;
        step();
        Start    = 1'b0;
        exp_addr = '0;
    endtask

    task automatic send(input logic [W-1:0] d);
        int n;
        n       = 0;
        InValid = 1'b1;
        InData  = d;
        while (InReady !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (InReady !== 1'b1) check("in_ready_wait", 32'(InReady), 32'd1);
        sb.push_back({exp_addr, d});
        exp_addr = exp_addr + 1'b1;
        step();
        InValid = 1'b0;
    endtask

    task automatic finish_load(input string tag, input logic exp_done);
        int n;
        n = 0;
        while (Busy === 1'b1 && n < 20) begin
            step();
            n++;
        end
        check({tag, "_busy"}, 32'(Busy), 32'd0);
        check({tag, "_done"}, 32'(Done), 32'(exp_done));
        check({tag, "_error"}, 32'(Error), 32'(!exp_done));
        check({tag, "_corehold"}, 32'(CoreHold), 32'(!exp_done));
        check({tag, "_sb_drained"}, 32'(sb.size()), 32'd0);
    endtask

    task automatic ram_check(input logic [A-1:0] a, input logic [W-1:0] d);
        RdAddr = a;
        #1;
        check("ram_read", 32'(RdData), 32'(d));
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_inready"}, 32'(InReady), 32'd0);
        check({tag, "_wren"}, 32'(WrEn), 32'd0);
        check({tag, "_wraddr"}, 32'(WrAddr), 32'd0);
        check({tag, "_wrdata"}, 32'(WrData), 32'd0);
        check({tag, "_busy"}, 32'(Busy), 32'd0);
        check({tag, "_done"}, 32'(Done), 32'd0);
        check({tag, "_error"}, 32'(Error), 32'd0);
        check({tag, "_corehold"}, 32'(CoreHold), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] words [4];
        words[0] = 9'h00C; words[1] = 9'h028; words[2] = 9'h0AA; words[3] = 9'h1FF;
        Reset = 1'b1; Start = 1'b0; LoadLen = '0; ExpSum = '0;
        InValid = 1'b0; InData = '0; RdAddr = '0; exp_addr = '0;
        step();
        step();
        check_reset("reset");
        Reset = 1'b0;
        step();

        // Basic back-to-back load.
        do_start(11'd4, 9'h171);
        check("start_busy", 32'(Busy), 32'd1);
        for (int i = 0; i < 4; i++) send(words[i]);
        finish_load("basic", 1'b1);
        for (int i = 0; i < 4; i++) ram_check(A'(i), words[i]);

        // Restart from DONE with source bubbles 1,0,1,0,1,1.
        do_start(11'd4, 9'h171);
        check("restart_corehold", 32'(CoreHold), 32'd1);
        check("restart_done_clr", 32'(Done), 32'd0);
        send(words[0]); step();
        send(words[1]); step();
        send(words[2]);
        send(words[3]);
        finish_load("bubbles", 1'b1);

        // Checksum mismatch, then a corrected load.
        do_start(11'd4, 9'h170);
        for (int i = 0; i < 4; i++) send(words[i]);
        finish_load("mismatch", 1'b0);
        do_start(11'd4, 9'h171);
        for (int i = 0; i < 4; i++) send(words[i]);
        finish_load("recover", 1'b1);

        // Bad lengths: no writes, Error one cycle after Start.
        do_start(11'd0, 9'h000);
        check("len0_error", 32'(Error), 32'd1);
        check("len0_done", 32'(Done), 32'd0);
        check("len0_corehold", 32'(CoreHold), 32'd1);
        check("len0_inready", 32'(InReady), 32'd0);
        step();
        check("len0_wren", 32'(WrEn), 32'd0);
        do_start(11'd1025, 9'h000);
        check("len1025_error", 32'(Error), 32'd1);
        check("len1025_busy", 32'(Busy), 32'd0);
        step();
        check("len1025_wren", 32'(WrEn), 32'd0);
        check("badlen_sb_drained", 32'(sb.size()), 32'd0);

        // Full memory with an incrementing pattern; 0..511 twice XORs to 0.
        do_start(11'd1024, 9'h000);
        for (int i = 0; i < 1024; i++) send(W'(i));
        finish_load("full", 1'b1);
        ram_check(10'd0, 9'h000);
        ram_check(10'd513, 9'h001);
        ram_check(10'd1023, 9'h1FF);

        // Reset after 2 of 4 beats, then reload from address 0.
        do_start(11'd4, 9'h171);
        send(words[0]);
        send(words[1]);
        Reset = 1'b1;
        step();
        check_reset("midreset");
        Reset = 1'b0;
        sb.delete();
        step();
        check("midreset_corehold_idle", 32'(CoreHold), 32'd1);
        do_start(11'd4, 9'h177);
        send(9'h101);
        send(9'h002);
        send(9'h030);
        send(9'h044);
        finish_load("reload", 1'b1);
        ram_check(10'd0, 9'h101);
        ram_check(10'd3, 9'h044);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
